alu_result_display: RTL

Downstream stage of the 4-bit ALU: consumes the registered 8-bit result and its overflow/zero flags and drives a 4-digit multiplexed seven-segment display plus two status LEDs. Each accepted result is converted from binary to three BCD digits by a sequential shift-add-3 (double-dabble) engine. The result is then shown in decimal with leading-zero blanking, and digit 3 shows `E` on overflow. This block is the board-facing output of the ALU datapath.

---
 rtl/alu_result_display_if.sv | 25 ++
 rtl/alu_result_display.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display_if.sv
// Bundle of the ALU-result handshake and the board-facing display outputs.
// The producer side (ALU or bench) uses the master modport; the display
// block uses the slave modport.
`timescale 1ns/1ps
interface alu_result_display_if;
  logic       load;
  logic [7:0] Y;
  logic       overflow;
  logic       zero;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  logic       ovf_led;
  logic       zero_led;

  modport master (
    output load, Y, overflow, zero,
    input  busy, seg, an, ovf_led, zero_led
  );

  modport slave (
    input  load, Y, overflow, zero,
    output busy, seg, an, ovf_led, zero_led
  );
endinterface

// File: rtl/alu_result_display.sv
// ALU result display stage: sequential double-dabble binary-to-BCD
// conversion with a one-deep newest-wins holding register, atomic update of
// the display registers, and a free-running 4-digit multiplexed scan with
// leading-zero blanking and an overflow 'E' on digit 3.
`timescale 1ns/1ps
module alu_result_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic                 clk,
  input logic                 rst,
  alu_result_display_if.slave bus
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      add3 = nib + 4'd3;
    end else begin
      add3 = nib;
    end
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] dig);
    case (dig)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Converter state
  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [7:0]  shift_r;
  logic [11:0] bcd_r;
  logic        cur_ovf_r;
  logic        cur_zero_r;

  // One-deep holding register for results arriving during a conversion
  logic [7:0]  hold_y_r;
  logic        hold_ovf_r;
  logic        hold_zero_r;
  logic        pending_r;

  // Display registers
  logic [3:0]  disp_h_r;
  logic [3:0]  disp_t_r;
  logic [3:0]  disp_u_r;
  logic        disp_ovf_r;
  logic        disp_zero_r;

  // Scan
  logic [DIV_W-1:0] div_r;
  logic [1:0]       idx_r;

  // Combinational helpers
  logic [11:0] bcd_adj_s;
  logic [19:0] step_s;
  logic [6:0]  seg_s;
  logic [3:0]  an_s;

  // One double-dabble iteration computed from the current converter registers.
  always_comb begin
    bcd_adj_s = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
    step_s    = {bcd_adj_s, shift_r} << 5'd1;
  end

  // Converter FSM: accept results, iterate, publish the final BCD, chain pending work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      shift_r     <= 8'd0;
      bcd_r       <= 12'd0;
      cur_ovf_r   <= 1'b0;
      cur_zero_r  <= 1'b0;
      hold_y_r    <= 8'd0;
      hold_ovf_r  <= 1'b0;
      hold_zero_r <= 1'b0;
      pending_r   <= 1'b0;
      disp_h_r    <= 4'd0;
      disp_t_r    <= 4'd0;
      disp_u_r    <= 4'd0;
      disp_ovf_r  <= 1'b0;
      disp_zero_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (pending_r) begin
            // A result parked on the last completing edge starts now.
            shift_r    <= hold_y_r;
            cur_ovf_r  <= hold_ovf_r;
            cur_zero_r <= hold_zero_r;
            bcd_r      <= 12'd0;
            cnt_r      <= 4'd0;
            state_r    <= CONV;
            if (bus.load) begin
              hold_y_r    <= bus.Y;
              hold_ovf_r  <= bus.overflow;
              hold_zero_r <= bus.zero;
              pending_r   <= 1'b1;
            end else begin
              pending_r   <= 1'b0;
            end
          end else if (bus.load) begin
            shift_r    <= bus.Y;
            cur_ovf_r  <= bus.overflow;
            cur_zero_r <= bus.zero;
            bcd_r      <= 12'd0;
            cnt_r      <= 4'd0;
            state_r    <= CONV;
          end else begin
            state_r    <= IDLE;
          end
        end
        CONV: begin
          bcd_r   <= step_s[19:8];
          shift_r <= step_s[7:0];
          cnt_r   <= cnt_r + 4'd1;
          if (cnt_r == 4'd7) begin
            // Publish all digits and flags together so no partial value is shown.
            disp_h_r    <= step_s[19:16];
            disp_t_r    <= step_s[15:12];
            disp_u_r    <= step_s[11:8];
            disp_ovf_r  <= cur_ovf_r;
            disp_zero_r <= cur_zero_r;
            if (pending_r) begin
              shift_r    <= hold_y_r;
              cur_ovf_r  <= hold_ovf_r;
              cur_zero_r <= hold_zero_r;
              bcd_r      <= 12'd0;
              cnt_r      <= 4'd0;
              state_r    <= CONV;
              pending_r  <= bus.load;
            end else begin
              state_r    <= IDLE;
              pending_r  <= bus.load;
            end
          end else begin
            if (bus.load) begin
              pending_r <= 1'b1;
            end else begin
              pending_r <= pending_r;
            end
          end
          // Any load during a conversion lands in the holding register; newest wins.
          if (bus.load) begin
            hold_y_r    <= bus.Y;
            hold_ovf_r  <= bus.overflow;
            hold_zero_r <= bus.zero;
          end else begin
            hold_y_r    <= hold_y_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Refresh divider and digit index; free-running, independent of conversion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r <= '0;
      idx_r <= 2'd0;
    end else if (div_r == DIV_LAST) begin
      div_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Digit select and segment decode from the display registers only.
  always_comb begin
    an_s = ~(4'b0001 << idx_r);
    case (idx_r)
      2'd0: seg_s = seg_code(disp_u_r);
      2'd1: begin
        if ((disp_h_r == 4'd0) && (disp_t_r == 4'd0)) begin
          seg_s = SEG_BLANK;
        end else begin
          seg_s = seg_code(disp_t_r);
        end
      end
      2'd2: begin
        if (disp_h_r == 4'd0) begin
          seg_s = SEG_BLANK;
        end else begin
          seg_s = seg_code(disp_h_r);
        end
      end
      2'd3: begin
        if (disp_ovf_r) begin
          seg_s = SEG_E;
        end else begin
          seg_s = SEG_BLANK;
        end
      end
      default: seg_s = SEG_BLANK;
    endcase
  end

  assign bus.seg      = seg_s;
  assign bus.an       = an_s;
  assign bus.busy     = (state_r == CONV);
  assign bus.ovf_led  = disp_ovf_r;
  assign bus.zero_led = disp_zero_r;

endmodule
